msb_lsb_packer: RTL and testbench

- Stream-to-array packer: accepts W-bit elements one per handshake and assembles them into a packed two-dimensional word [N-1:0][W-1:0].
- Writer-side counterpart of the MSB/LSB element-extraction logic. Downstream consumers index the result with msb/lsb element selects.
- Sits between a narrow element producer and a wide consumer. Fill order is selectable (MSB lane first or LSB lane first), and a partial word can be flushed early.

---
 rtl/msb_lsb_packer.sv | 140 ++++++++++++++
 tb/tb_msb_lsb_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/msb_lsb_packer.sv
// msb_lsb_packer: collects W-bit elements, one per handshake, into a packed
// [N-1:0][W-1:0] word. The fill order is selectable: MSB lane first, or LSB
// lane first. An element that carries i_last flushes a partial word early,
// and the lanes it did not fill read as zero.
//
// Handshake rules, the same on both sides: a transfer happens on a rising
// clock edge where valid && ready. A producer that raises valid keeps it high,
// and keeps its payload stable, until that transfer happens. ready may be
// computed combinationally from the other side's ready.
module msb_lsb_packer #(
    parameter int W         = 20,
    parameter int N         = 10,
    parameter int MSB_FIRST = 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [W-1:0]                        i_data,
    input  logic                                i_last,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [N-1:0][W-1:0]                 o_data,
    output logic [$clog2(N+1)-1:0]              o_count,
    output logic                                dbg_state
);

    localparam int CW = $clog2(N+1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // START_LANE receives the first element of a word.
    // END_LANE is the lane whose write closes the word.
    localparam logic [PW-1:0] START_LANE = (MSB_FIRST != 0) ? PW'(N-1) : PW'(0);
    localparam logic [PW-1:0] END_LANE   = (MSB_FIRST != 0) ? PW'(0)   : PW'(N-1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0][W-1:0]    data_q, data_d;
    logic [CW-1:0]          ocnt_q, ocnt_d;
    logic                   accept;
    logic                   drain;

    // Step the lane pointer one lane toward the end lane.
    function automatic logic [PW-1:0] step_lane(input logic [PW-1:0] p);
        if (MSB_FIRST != 0) begin
            return p - PW'(1);
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Outputs and handshake terms. In HOLD, ready follows the consumer, so the
    // next word can start on the same cycle the current one drains.
    always_comb begin
        o_valid   = (state_q == HOLD);
        o_ready   = (state_q == FILL) || i_ready;
        o_data    = data_q;
        o_count   = ocnt_q;
        dbg_state = state_q;
        accept    = i_valid && o_ready;
        drain     = o_valid && i_ready;
    end

    // Next-state logic. Once a word closes, ptr and cnt are reloaded at once,
    // so an element accepted on the drain cycle always lands in the start lane.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ocnt_d  = ocnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    data_d[ptr_q] = i_data;
                    if ((ptr_q == END_LANE) || i_last) begin
                        state_d = HOLD;
                        ocnt_d  = cnt_q + CW'(1);
                        cnt_d   = '0;
                        ptr_d   = START_LANE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        ptr_d = step_lane(ptr_q);
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    data_d  = '0;
                    ocnt_d  = '0;
                    cnt_d   = '0;
                    ptr_d   = START_LANE;
                    state_d = FILL;
                    if (accept) begin
                        data_d[START_LANE] = i_data;
                        if (i_last) begin
                            // A one-element word flushes immediately.
                            state_d = HOLD;
                            ocnt_d  = CW'(1);
                        end else begin
                            cnt_d = CW'(1);
                            ptr_d = step_lane(START_LANE);
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                ptr_d   = START_LANE;
                cnt_d   = '0;
                data_d  = '0;
                ocnt_d  = '0;
            end
        endcase
    end

    // State registers. Reset is asynchronous and discards any partial word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= FILL;
            ptr_q   <= START_LANE;
            cnt_q   <= '0;
            data_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ocnt_q  <= ocnt_d;
        end
    end

endmodule

// File: tb/tb_msb_lsb_packer.sv
// Bench for msb_lsb_packer. It runs two instances side by side with W=8 and
// N=4. One fills MSB-first and the other LSB-first, and both see the same
// input stream.
module tb_msb_lsb_packer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N+1);

    // Clock and reset.
    logic clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 clk = ~clk;

    logic               i_valid = 1'b0;
    logic [W-1:0]       i_data  = '0;
    logic               i_last  = 1'b0;
    logic               i_ready = 1'b1;

    logic               o_ready_m, o_valid_m, dbg_m;
    logic [N-1:0][W-1:0] o_data_m;
    logic [CW-1:0]      o_count_m;
    logic               o_ready_l, o_valid_l, dbg_l;
    logic [N-1:0][W-1:0] o_data_l;
    logic [CW-1:0]      o_count_l;

    msb_lsb_packer #(.W(W), .N(N), .MSB_FIRST(1)) dut_m (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_m),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid_m), .i_ready(i_ready),
        .o_data(o_data_m), .o_count(o_count_m), .dbg_state(dbg_m)
    );

    msb_lsb_packer #(.W(W), .N(N), .MSB_FIRST(0)) dut_l (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_l),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid_l), .i_ready(i_ready),
        .o_data(o_data_l), .o_count(o_count_l), .dbg_state(dbg_l)
    );

    int checks = 0;
    int fails  = 0;
    int cycles = 0;

    always @(posedge clk) cycles <= cycles + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model. Each word is the list of elements accepted since the
    // previous word closed. The list closes when it reaches N elements or when
    // an element arrives with i_last. The MSB-first instance places element j
    // in lane N-1-j, and the LSB-first instance places it in lane j.
    logic [W-1:0]  elems[$];
    logic          exp_valid = 1'b0;
    logic [31:0]   exp_m = '0;
    logic [31:0]   exp_l = '0;
    int            exp_cnt = 0;
    logic          m_acc, m_dr;

    always @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            exp_valid = 1'b0;
            elems.delete();
            exp_m = '0;
            exp_l = '0;
            exp_cnt = 0;
        end else begin
            m_acc = i_valid && (!exp_valid || i_ready);
            m_dr  = exp_valid && i_ready;
            if (m_dr) exp_valid = 1'b0;
            if (m_acc) begin
                elems.push_back(i_data);
                if (elems.size() == N || i_last) begin
                    exp_m = '0;
                    exp_l = '0;
                    for (int j = 0; j < elems.size(); j++) begin
                        exp_m[(N-1-j)*W +: W] = elems[j];
                        exp_l[j*W +: W]       = elems[j];
                    end
                    exp_cnt   = elems.size();
                    exp_valid = 1'b1;
                    elems.delete();
                end
            end
        end
    end

    // Scoreboard of words the consumer actually took, in order.
    logic [31:0] got_m[$];
    logic [31:0] got_l[$];

    // Compare process. It checks both instances against the model on every
    // falling edge while reset is released.
    always @(negedge clk) begin
        if (i_rst) begin
            check("o_valid_m", {31'b0, o_valid_m}, {31'b0, exp_valid});
            check("o_valid_l", {31'b0, o_valid_l}, {31'b0, exp_valid});
            check("o_ready_m", {31'b0, o_ready_m}, {31'b0, (!exp_valid || i_ready)});
            check("o_ready_l", {31'b0, o_ready_l}, {31'b0, (!exp_valid || i_ready)});
            if (exp_valid) begin
                check("o_data_m", o_data_m, exp_m);
                check("o_data_l", o_data_l, exp_l);
                check("o_count_m", 32'(o_count_m), 32'(exp_cnt));
                check("o_count_l", 32'(o_count_l), 32'(exp_cnt));
            end
            if (o_valid_m && i_ready) got_m.push_back(o_data_m);
            if (o_valid_l && i_ready) got_l.push_back(o_data_l);
        end
    end

    // Driver: present one element and hold it until it is accepted.
    // The task returns just after the accepting clock edge.
    task automatic send(input logic [W-1:0] d, input logic l);
        bit done = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (o_ready_m) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: element 0x%0h not accepted within 50 cycles", d);
        end
    endtask

    // Idle cycles. i_last is held high here with i_valid low, and the packer
    // must ignore it.
    task automatic idle(input int n);
        i_valid = 1'b0;
        i_last  = 1'b1;
        i_data  = W'($urandom_range(0, 255));
        repeat (n) @(posedge clk);
        #1;
        i_last = 1'b0;
    endtask

    logic [31:0] lit_m[9] = '{32'h11223344, 32'hA1B20000, 32'h01020304, 32'hC1C2C3C4,
                              32'h55667788, 32'h10111213, 32'h14151617, 32'h18191A1B,
                              32'hF1F2F3F4};
    logic [31:0] lit_l[9] = '{32'h44332211, 32'h0000B2A1, 32'h04030201, 32'hC4C3C2C1,
                              32'h88776655, 32'h13121110, 32'h17161514, 32'h1B1A1918,
                              32'hF4F3F2F1};

    initial begin
        int t0;
        int w0;
        // Reset values, checked while reset is asserted.
        #12;
        check("rst_o_valid", {30'b0, o_valid_m, o_valid_l}, 32'h0);
        check("rst_o_data_m", o_data_m, 32'h0);
        check("rst_o_data_l", o_data_l, 32'h0);
        check("rst_o_count", {o_count_m, o_count_l}, 32'h0);
        @(posedge clk);
        #1 i_rst = 1'b1;
        #1;
        check("rst_rel_o_ready", {30'b0, o_ready_m, o_ready_l}, 32'h3);

        // One full word, sent back-to-back.
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        i_valid = 1'b0;
        #1;
        check("latency_o_valid", {30'b0, o_valid_m, o_valid_l}, 32'h3);
        idle(3);

        // A partial word flushed with i_last, then a word whose end element
        // also carries i_last.
        send(8'hA1, 0); send(8'hB2, 1);
        idle(2);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        idle(3);

        // Backpressure. Fill a word with i_ready low, then keep offering 0x55
        // for 5 cycles while the word is held.
        i_ready = 1'b0;
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
        fork
            send(8'h55, 0);
            begin
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        idle(3);

        // Continuous stream of three words: 12 accepts in 12 cycles.
        t0 = cycles;
        w0 = got_m.size();
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 0);
        check("stream_cycles", 32'(cycles - t0), 32'd12);
        idle(3);
        check("stream_words", 32'(got_m.size() - w0), 32'd3);

        // Reset asserted mid-word. The partial word is discarded.
        send(8'hE1, 0); send(8'hE2, 0);
        i_valid = 1'b0;
        i_rst   = 1'b0;
        #1;
        check("midrst_o_valid", {30'b0, o_valid_m, o_valid_l}, 32'h0);
        check("midrst_o_data", o_data_m | o_data_l, 32'h0);
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b1;
        send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'hF4, 0);
        idle(4);

        // Words the consumer took, compared with hand-computed literals.
        check("word_count_m", 32'(got_m.size()), 32'd9);
        check("word_count_l", 32'(got_l.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_m.size()) check($sformatf("word_m[%0d]", i), got_m[i], lit_m[i]);
            if (i < got_l.size()) check($sformatf("word_l[%0d]", i), got_l[i], lit_l[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Safety bound on the whole run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
